// File: rtl/apu_pkg.sv
// ---------------------------------------------------------------------------
// apu_pkg
// Shared types and helpers for the time-multiplexed voice mixer.
//   mix_state_e : mixer sequencer states
//   MIX_LAT     : strobe-to-mix_valid latency for the default voice count
//   sat_s16     : signed clamp of a 32-bit value to a width of 'width' bits
// ---------------------------------------------------------------------------
package apu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ENV,
        ST_VOL,
        ST_ACC,
        ST_MASTER,
        ST_DONE
    } mix_state_e;

    localparam int DEF_NUM_CH = 8;
    localparam int MIX_LAT    = 4 * DEF_NUM_CH + 2;
    localparam int SAT_W      = 32;

    // Clamp to [-2^(width-1), 2^(width-1)-1]; the caller truncates the
    // result to 'width' bits.
    function automatic logic signed [SAT_W-1:0] sat_s16(
        input logic signed [SAT_W-1:0] value,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/mix_mac.sv
// ---------------------------------------------------------------------------
// mix_mac
// Combinational signed multiply, optional arithmetic right shift (floor) and
// saturating add.  One instance per stereo side is time-shared by the
// volume, accumulate and master-volume steps through an operand mux.
//   a      in  W       signed multiplicand
//   b      in  COEF_W  signed coefficient
//   scale  in  1       1: product >>> SHIFT, 0: product unshifted
//   addend in  W       signed value added after scaling
//   result out W       sat_W(addend + scaled product)
// ---------------------------------------------------------------------------
module mix_mac
    import apu_pkg::*;
#(
    parameter int W      = 16,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 7
) (
    input  logic signed [W-1:0]      a,
    input  logic signed [COEF_W-1:0] b,
    input  logic                     scale,
    input  logic signed [W-1:0]      addend,
    output logic signed [W-1:0]      result
);

    localparam int PROD_W = W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] scaled;
    logic signed [SUM_W-1:0]  sum;

    assign prod   = PROD_W'(a) * PROD_W'(b);
    assign scaled = scale ? (prod >>> SHIFT) : prod;
    assign sum    = SUM_W'(scaled) + SUM_W'(addend);
    assign result = W'(sat_s16(SAT_W'(sum), W));

endmodule

// File: rtl/dsp_voice_mixer.sv
// ---------------------------------------------------------------------------
// dsp_voice_mixer
// Time-multiplexed N-voice mixer.  On each frame strobe the voices are
// scanned one at a time (FETCH/ENV/VOL/ACC), envelope and voice volume are
// applied, the results are saturating-summed into L/R accumulators, and the
// master volume is applied before the frame result is published.
// Optional feature macro: DSP_MIX_ECHO_EN adds echo-send accumulators fed by
// voices with ch_eon=1 (no master volume, mute ignored); without it echo_l/r
// are tied to 0 and ch_eon is ignored.
// Ports:
//   clk, reset(active-low, async)  clock / reset
//   exe_32khz                      frame start strobe
//   ch_sel                         voice index presented to the voice array
//   ch_sample/level/vol_l/vol_r/eon voice data for ch_sel, sampled at the end
//                                  of the cycle following the ch_sel update
//   mvol_l/r, mute                 master volume / mute, used at frame end
//   outx_we, outx_ch, outx         post-envelope sample of each voice
//   mix_l/r, echo_l/r, mix_valid   frame results and their update pulse
//   overrun                        strobe arrived while a frame was running
// ---------------------------------------------------------------------------
module dsp_voice_mixer
    import apu_pkg::*;
#(
    parameter int  NUM_CH   = DEF_NUM_CH,
    parameter int  SAMPLE_W = 15,
    parameter int  LEVEL_W  = 11,
    parameter int  VOL_W    = 8,
    parameter int  OUT_W    = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       exe_32khz,
    output logic        [CH_W-1:0]     ch_sel,
    input  logic signed [SAMPLE_W-1:0] ch_sample,
    input  logic        [LEVEL_W-1:0]  ch_level,
    input  logic signed [VOL_W-1:0]    ch_vol_l,
    input  logic signed [VOL_W-1:0]    ch_vol_r,
    input  logic                       ch_eon,
    input  logic signed [VOL_W-1:0]    mvol_l,
    input  logic signed [VOL_W-1:0]    mvol_r,
    input  logic                       mute,
    output logic                       outx_we,
    output logic        [CH_W-1:0]     outx_ch,
    output logic signed [SAMPLE_W-1:0] outx,
    output logic signed [OUT_W-1:0]    mix_l,
    output logic signed [OUT_W-1:0]    mix_r,
    output logic signed [OUT_W-1:0]    echo_l,
    output logic signed [OUT_W-1:0]    echo_r,
    output logic                       mix_valid,
    output logic                       overrun
);

    localparam int             ENV_W   = SAMPLE_W + LEVEL_W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Index 0 is the left side, index 1 the right side.
    mix_state_e              state_reg;
    logic [CH_W-1:0]         idx_reg;
    logic signed [OUT_W-1:0] acc_reg [2];
    logic signed [OUT_W-1:0] p_reg   [2];
    logic signed [VOL_W-1:0] vol_reg [2];
    logic signed [OUT_W-1:0] mix_reg [2];

    logic signed [VOL_W-1:0] ch_vol  [2];
    logic signed [VOL_W-1:0] mvol    [2];
    logic signed [OUT_W-1:0] mac_a   [2];
    logic signed [VOL_W-1:0] mac_b   [2];
    logic signed [OUT_W-1:0] mac_add [2];
    logic signed [OUT_W-1:0] mac_res [2];
    logic                    mac_scale;

    logic signed [ENV_W-1:0]    env_full;
    logic signed [SAMPLE_W-1:0] outx_next;

    assign ch_vol[0] = ch_vol_l;
    assign ch_vol[1] = ch_vol_r;
    assign mvol[0]   = mvol_l;
    assign mvol[1]   = mvol_r;
    assign mix_l     = mix_reg[0];
    assign mix_r     = mix_reg[1];

    // Envelope: level is unsigned, so it is zero-extended before the signed
    // multiply; the shift by LEVEL_W keeps full-scale level just below unity.
    assign env_full  = ENV_W'(ch_sample) * $signed(ENV_W'(ch_level));
    assign outx_next = SAMPLE_W'(env_full >>> LEVEL_W);

    // Operand mux for the shared multiply/add: VOL scales outx by the voice
    // volume, ACC adds p (times 1, unshifted) to the accumulator, MASTER
    // scales the accumulator by the master volume.
    always_comb begin
        mac_scale = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mac_a[i]   = OUT_W'(outx);
            mac_b[i]   = vol_reg[i];
            mac_add[i] = '0;
        end
        case (state_reg)
            ST_ACC: begin
                mac_scale = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    mac_a[i]   = p_reg[i];
                    mac_b[i]   = VOL_W'(1);
                    mac_add[i] = acc_reg[i];
                end
            end
            ST_MASTER: begin
                for (int i = 0; i < 2; i++) begin
                    mac_a[i] = acc_reg[i];
                    mac_b[i] = mvol[i];
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            mix_mac #(
                .W      (OUT_W),
                .COEF_W (VOL_W),
                .SHIFT  (VOL_W - 1)
            ) u_mac (
                .a      (mac_a[gi]),
                .b      (mac_b[gi]),
                .scale  (mac_scale),
                .addend (mac_add[gi]),
                .result (mac_res[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            ch_sel    <= '0;
            outx_ch   <= '0;
            outx      <= '0;
            outx_we   <= 1'b0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                acc_reg[i] <= '0;
                p_reg[i]   <= '0;
                vol_reg[i] <= '0;
                mix_reg[i] <= '0;
            end
        end else begin
            outx_we   <= 1'b0;
            mix_valid <= 1'b0;
            // Any strobe that does not start a frame (including one in DONE)
            // is dropped and flagged one cycle later.
            overrun   <= exe_32khz && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (exe_32khz) begin
                        idx_reg <= '0;
                        for (int i = 0; i < 2; i++) begin
                            acc_reg[i] <= '0;
                        end
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ch_sel    <= idx_reg;
                    state_reg <= ST_ENV;
                end
                ST_ENV: begin
                    outx    <= outx_next;
                    outx_ch <= idx_reg;
                    outx_we <= 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        vol_reg[i] <= ch_vol[i];
                    end
                    state_reg <= ST_VOL;
                end
                ST_VOL: begin
                    for (int i = 0; i < 2; i++) begin
                        p_reg[i] <= mac_res[i];
                    end
                    state_reg <= ST_ACC;
                end
                ST_ACC: begin
                    for (int i = 0; i < 2; i++) begin
                        acc_reg[i] <= mac_res[i];
                    end
                    if (idx_reg == LAST_CH) begin
                        state_reg <= ST_MASTER;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_MASTER: begin
                    // Result registered here so it is already on mix_l/r
                    // during the DONE cycle that carries mix_valid.
                    for (int i = 0; i < 2; i++) begin
                        mix_reg[i] <= mute ? '0 : mac_res[i];
                    end
                    mix_valid <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DSP_MIX_ECHO_EN
    logic signed [OUT_W-1:0] echo_acc_reg [2];
    logic signed [OUT_W-1:0] echo_reg     [2];
    logic                    eon_reg;

    assign echo_l = echo_reg[0];
    assign echo_r = echo_reg[1];

    // Echo path follows the main sequencer; p is shared with the mix path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eon_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                echo_acc_reg[i] <= '0;
                echo_reg[i]     <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (exe_32khz) begin
                        for (int i = 0; i < 2; i++) begin
                            echo_acc_reg[i] <= '0;
                        end
                    end
                end
                ST_ENV: eon_reg <= ch_eon;
                ST_ACC: begin
                    if (eon_reg) begin
                        for (int i = 0; i < 2; i++) begin
                            echo_acc_reg[i] <= OUT_W'(sat_s16(
                                SAT_W'(echo_acc_reg[i]) + SAT_W'(p_reg[i]), OUT_W));
                        end
                    end
                end
                ST_MASTER: begin
                    for (int i = 0; i < 2; i++) begin
                        echo_reg[i] <= echo_acc_reg[i];
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_eon;
    assign unused_eon = ch_eon;
    assign echo_l     = '0;
    assign echo_r     = '0;
`endif

endmodule
